// File: rtl/icache_direct.sv
// rtl/icache_direct.sv - direct-mapped read-only instruction cache, one word per set
// Optional hit/miss counters are built when ICACHE_STATS_EN is defined.
module icache_direct #(
   parameter int SETS = 16
) (
   input  logic        CLK,
   input  logic        nRST,
   input  logic        imemREN,
   input  logic [31:0] imemaddr,
   output logic        ihit,
   output logic [31:0] imemload,
   output logic        iREN,
   output logic [31:0] iaddr,
   input  logic        iwait,
   input  logic [31:0] iload
`ifdef ICACHE_STATS_EN
   ,
   output logic [31:0] hit_count,
   output logic [31:0] miss_count
`endif
);

   localparam int IDX_W = $clog2(SETS);
   localparam int TAG_W = 30 - IDX_W;

   typedef enum logic {
      IDLE,
      FETCH
   } state_t;

   state_t state, state_nxt;

   logic [29:0]      miss_addr;
   logic             valid_q [SETS];
   logic [TAG_W-1:0] tag_q   [SETS];
   logic [31:0]      data_q  [SETS];

   logic [IDX_W-1:0] req_idx;
   logic [TAG_W-1:0] req_tag;
   logic [IDX_W-1:0] fill_idx;
   logic [TAG_W-1:0] fill_tag;
   logic             lookup_hit;
   logic             latch_miss;
   logic             fill_en;
   logic             unused_addr_bits;

   assign req_idx          = imemaddr[IDX_W+1:2];
   assign req_tag          = imemaddr[31:IDX_W+2];
   assign fill_idx         = miss_addr[IDX_W-1:0];
   assign fill_tag         = miss_addr[29:IDX_W];
   assign unused_addr_bits = ^imemaddr[1:0];

   assign lookup_hit = valid_q[req_idx] && (tag_q[req_idx] == req_tag);
   // Data is shown regardless of hit; the datapath only looks at it when ihit=1.
   assign imemload   = data_q[req_idx];
   assign iaddr      = {miss_addr, 2'b00};

   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt  = state;
      ihit       = 1'b0;
      iREN       = 1'b0;
      latch_miss = 1'b0;
      fill_en    = 1'b0;
      case (state)
         IDLE: begin
            if (imemREN) begin
               if (lookup_hit) begin
                  ihit = 1'b1;
               end else begin
                  latch_miss = 1'b1;
                  state_nxt  = FETCH;
               end
            end
         end
         FETCH: begin
            // The fill always completes for the latched address, even if the
            // request moved away while memory was busy.
            iREN = 1'b1;
            if (!iwait) begin
               fill_en   = 1'b1;
               state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         miss_addr <= '0;
         for (int i = 0; i < SETS; i++) begin
            valid_q[i] <= 1'b0;
            tag_q[i]   <= '0;
            data_q[i]  <= '0;
         end
      end else begin
         if (latch_miss) begin
            miss_addr <= imemaddr[31:2];
         end
         if (fill_en) begin
            valid_q[fill_idx] <= 1'b1;
            tag_q[fill_idx]   <= fill_tag;
            data_q[fill_idx]  <= iload;
         end
      end
   end

`ifdef ICACHE_STATS_EN
   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         hit_count  <= '0;
         miss_count <= '0;
      end else begin
         if (ihit) begin
            hit_count <= hit_count + 32'd1;
         end
         if (latch_miss) begin
            miss_count <= miss_count + 32'd1;
         end
      end
   end
`endif

endmodule

// File: tb/tb_icache_direct.sv
// tb/tb_icache_direct.sv - self-checking bench for icache_direct
module tb_icache_direct;

   localparam int SETS  = 16;
   localparam int IDX_W = $clog2(SETS);

   logic        CLK;
   logic        nRST;
   logic        imemREN;
   logic [31:0] imemaddr;
   logic        ihit;
   logic [31:0] imemload;
   logic        iREN;
   logic [31:0] iaddr;
   logic        iwait;
   logic [31:0] iload;
`ifdef ICACHE_STATS_EN
   logic [31:0] hit_count;
   logic [31:0] miss_count;
`endif

   icache_direct #(.SETS(SETS)) dut (
      .CLK      (CLK),
      .nRST     (nRST),
      .imemREN  (imemREN),
      .imemaddr (imemaddr),
      .ihit     (ihit),
      .imemload (imemload),
      .iREN     (iREN),
      .iaddr    (iaddr),
      .iwait    (iwait),
      .iload    (iload)
`ifdef ICACHE_STATS_EN
      ,
      .hit_count  (hit_count),
      .miss_count (miss_count)
`endif
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   int checks = 0;
   int errors = 0;

   // Reference model: a table of resident words plus one outstanding fill.
   bit          m_valid [SETS];
   int unsigned m_tag   [SETS];
   logic [31:0] m_data  [SETS];
   bit          m_busy;
   logic [31:0] m_fill_addr;
   logic [31:0] m_hits;
   logic [31:0] m_misses;
   bit          cmp_on = 0;

   function automatic int unsigned set_of(input logic [31:0] a);
      return (a >> 2) % SETS;
   endfunction

   function automatic int unsigned tag_of(input logic [31:0] a);
      return a >> (2 + IDX_W);
   endfunction

   function automatic bit model_hit();
      return !m_busy && imemREN && m_valid[set_of(imemaddr)]
             && (m_tag[set_of(imemaddr)] == tag_of(imemaddr));
   endfunction

   task automatic model_reset();
      for (int i = 0; i < SETS; i++) begin
         m_valid[i] = 0;
         m_tag[i]   = 0;
         m_data[i]  = '0;
      end
      m_busy      = 0;
      m_fill_addr = '0;
      m_hits      = '0;
      m_misses    = '0;
   endtask

   task automatic model_step();
      if (model_hit()) begin
         m_hits = m_hits + 1;
      end
      if (m_busy) begin
         if (!iwait) begin
            m_valid[set_of(m_fill_addr)] = 1;
            m_tag[set_of(m_fill_addr)]   = tag_of(m_fill_addr);
            m_data[set_of(m_fill_addr)]  = iload;
            m_busy = 0;
         end
      end else if (imemREN && !model_hit()) begin
         m_busy      = 1;
         m_fill_addr = {imemaddr[31:2], 2'b00};
         m_misses    = m_misses + 1;
      end
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
      end
   endtask

   always @(negedge CLK) begin
      if (cmp_on) begin
         chk("ihit", {31'd0, ihit}, {31'd0, model_hit()});
         chk("iREN", {31'd0, iREN}, {31'd0, m_busy});
         if (m_busy) begin
            chk("iaddr", iaddr, m_fill_addr);
         end
         if (model_hit()) begin
            chk("imemload", imemload, m_data[set_of(imemaddr)]);
         end
`ifdef ICACHE_STATS_EN
         chk("hit_count", hit_count, m_hits);
         chk("miss_count", miss_count, m_misses);
`endif
      end
   end

   task automatic tick();
      @(posedge CLK);
      if (nRST) begin
         model_step();
      end
      #1;
   endtask

   initial begin
      nRST     = 1'b0;
      imemREN  = 1'b0;
      imemaddr = '0;
      iwait    = 1'b0;
      iload    = '0;
      model_reset();
      tick();
      tick();
      chk("rst_ihit", {31'd0, ihit}, 32'd0);
      chk("rst_iREN", {31'd0, iREN}, 32'd0);
      chk("rst_iaddr", iaddr, 32'd0);
      chk("rst_imemload", imemload, 32'd0);
      nRST   = 1'b1;
      cmp_on = 1;

      // Cold miss
      imemREN = 1'b1; imemaddr = 32'h4; iwait = 1'b0; iload = 32'h8C22_0000;
      #1;
      chk("cold_c0_ihit", {31'd0, ihit}, 32'd0);
      chk("cold_c0_iREN", {31'd0, iREN}, 32'd0);
      tick(); #1;
      chk("cold_c1_iREN", {31'd0, iREN}, 32'd1);
      chk("cold_c1_iaddr", iaddr, 32'h4);
      tick(); #1;
      chk("cold_c2_ihit", {31'd0, ihit}, 32'd1);
      chk("cold_c2_load", imemload, 32'h8C22_0000);
      chk("cold_c2_iREN", {31'd0, iREN}, 32'd0);
      iload = 32'hDEAD_BEEF;
      for (int i = 0; i < 3; i++) begin
         tick(); #1;
         chk("rehit_ihit", {31'd0, ihit}, 32'd1);
         chk("rehit_iREN", {31'd0, iREN}, 32'd0);
         chk("rehit_load", imemload, 32'h8C22_0000);
      end

      // Conflict eviction
      tick();
      imemaddr = 32'h0; iload = 32'h1111_1111;
      tick(); tick(); #1;
      chk("conf_fill0", imemload, 32'h1111_1111);
      tick();
      imemaddr = 32'h40; iload = 32'h2222_2222; #1;
      chk("conf_miss40", {31'd0, ihit}, 32'd0);
      tick(); #1;
      chk("conf_iaddr40", iaddr, 32'h40);
      tick(); #1;
      chk("conf_hit40", {31'd0, ihit}, 32'd1);
      chk("conf_load40", imemload, 32'h2222_2222);
      tick();
      imemaddr = 32'h0; iload = 32'h1111_1111; #1;
      chk("conf_remiss0", {31'd0, ihit}, 32'd0);
      tick(); #1;
      chk("conf_refetch_iREN", {31'd0, iREN}, 32'd1);
      chk("conf_refetch_iaddr", iaddr, 32'h0);
      tick();

      // Long memory latency
      imemaddr = 32'h100; iwait = 1'b1; iload = 32'h3333_3333; #1;
      chk("lat_miss", {31'd0, ihit}, 32'd0);
      tick();
      for (int i = 0; i < 6; i++) begin
         if (i == 5) iwait = 1'b0;
         #1;
         chk("lat_iREN", {31'd0, iREN}, 32'd1);
         chk("lat_iaddr", iaddr, 32'h100);
         chk("lat_ihit", {31'd0, ihit}, 32'd0);
         tick();
      end
      #1;
      chk("lat_hit", {31'd0, ihit}, 32'd1);
      chk("lat_load", imemload, 32'h3333_3333);
      tick();

      // Address change mid-fill
      imemaddr = 32'h8; iwait = 1'b1; iload = 32'hAAAA_0008;
      tick();
      imemaddr = 32'hC; #1;
      chk("mid_iaddr", iaddr, 32'h8);
      tick();
      iwait = 1'b0;
      tick(); #1;
      chk("mid_missC", {31'd0, ihit}, 32'd0);
      chk("mid_idle_iREN", {31'd0, iREN}, 32'd0);
      tick(); #1;
      chk("mid_fetchC", iaddr, 32'hC);
      iload = 32'hBBBB_000C;
      tick(); #1;
      chk("mid_loadC", imemload, 32'hBBBB_000C);
      tick();
      imemaddr = 32'h8; #1;
      chk("mid_hit8", {31'd0, ihit}, 32'd1);
      chk("mid_load8", imemload, 32'hAAAA_0008);
      tick();

      // Reset mid-fetch
      imemaddr = 32'h4; #1;
      chk("pre_rst_hit4", {31'd0, ihit}, 32'd1);
      tick();
      imemaddr = 32'h44; iwait = 1'b1;
      tick(); #2;
      nRST = 1'b0; #1;
      chk("rst_async_iREN", {31'd0, iREN}, 32'd0);
      model_reset();
`ifdef ICACHE_STATS_EN
      chk("rst_hit_count", hit_count, 32'd0);
      chk("rst_miss_count", miss_count, 32'd0);
`endif
      tick();
      nRST = 1'b1;
      imemaddr = 32'h4; iwait = 1'b0; iload = 32'h4444_4444; #1;
      chk("rst_miss4", {31'd0, ihit}, 32'd0);
      tick();

      // Randomised traffic over a small address pool so conflicts and hits recur
      for (int n = 0; n < 3000; n++) begin
         int unsigned t;
         logic [31:0] a;
         t = $urandom_range(0, 3);
         a = (32'(t) << 6) | (32'($urandom_range(0, SETS - 1)) << 2) | 32'($urandom_range(0, 3));
         if (t == 3) a = a | 32'h8000_0000;
         imemREN = ($urandom_range(0, 9) < 8);
         if ($urandom_range(0, 2) != 0) imemaddr = a;
         iwait = ($urandom_range(0, 9) < 3);
         iload = $urandom;
         tick();
      end

      cmp_on = 0;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/icache_direct.md
Name: icache_direct

Overview:
- Direct-mapped, read-only instruction cache. It sits between the pipelined datapath's instruction fetch port and the memory controller's instruction port.
- It consumes the datapath's imemREN/imemaddr and returns ihit/imemload.
- On a miss it fetches one word from memory through an iREN/iwait handshake.
- The datapath gates PC advance and the IF/ID register with ihit, so hit timing is architectural.

Parameters:
- SETS, 16, number of one-word blocks; power of two, 2..256.
- IDX_W, $clog2(SETS), index width; derived, never overridden.

Ports:
- CLK  input  1  clock, rising-edge.
- nRST  input  1  asynchronous active-low reset.
- imemREN  input  1  datapath instruction read request.
- imemaddr  input  32  byte address from PC; bits [1:0] ignored.
- ihit  output  1  requested word valid on imemload this cycle.
- imemload  output  32  instruction word.
- iREN  output  1  memory read request.
- iaddr  output  32  memory word address, bits [1:0] = 0.
- iwait  input  1  memory busy; data valid in the cycle iwait=0 while iREN=1.
- iload  input  32  memory read data.

Behaviour:
- Clock and reset: one clock (CLK). Reset nRST is asynchronous, active-low.
- Address split: index = imemaddr[IDX_W+1:2]; tag = imemaddr[31:IDX_W+2].
- Storage per set: valid bit, tag, 32-bit data word.
- Reset state (asserting edge of nRST, asynchronous):
  - all valid bits = 0; tags and data = 0;
  - state = IDLE; latched miss address = 0;
  - ihit = 0, imemload = 0, iREN = 0, iaddr = 0.
- Hit path (combinational, 0-cycle latency): in IDLE, ihit = imemREN & valid[index] & (tag == stored tag), and imemload = stored data[index].
  - When ihit=0, imemload still shows data[index] (don't-care to the datapath). The bench must not check imemload when ihit=0.
- FSM states: IDLE, FETCH.
- IDLE:
  - If imemREN=1 and the lookup misses: latch imemaddr[31:2] into miss_addr and go to FETCH next cycle.
  - No memory request is issued in the miss cycle itself (iREN=0).
  - imemREN=0: stay in IDLE, ihit=0, no memory activity.
- FETCH:
  - iREN=1 and iaddr = {miss_addr, 2'b00}, held constant until completion. ihit=0.
  - While iwait=1: hold.
  - When iwait=0: write valid=1, tag and data=iload into set miss_addr[IDX_W-1:0]; return to IDLE.
  - The requested word hits in the following cycle if imemaddr is unchanged.
- Minimum miss penalty: 2 cycles from the miss cycle to ihit (miss cycle plus a FETCH cycle with iwait=0). Each extra iwait=1 cycle adds one cycle.
- Boundary conditions:
  - imemaddr or imemREN changes during FETCH: the fill completes for the latched address, then the FSM returns to IDLE and re-evaluates the current request. No abort and no second request is issued mid-fill.
  - Conflict: a fill overwrites the resident tag/data unconditionally. There is no replacement choice.
  - Reset asserted mid-FETCH: immediately IDLE, iREN drops to 0 asynchronously, and the partial fill is discarded.
  - Cache contents are never written by the datapath; there is no coherence or invalidate port.

Optional Feature:
- Macro: ICACHE_STATS_EN.
- Defined:
  - Adds output ports hit_count[31:0] and miss_count[31:0], both reset to 0.
  - hit_count increments on each rising edge where ihit=1.
  - miss_count increments once per IDLE→FETCH transition.
  - Both counters wrap from 0xFFFFFFFF to 0.
- Undefined: the ports and counters do not exist, and behaviour is otherwise identical.

Test Plan:
- Cold miss: after reset, imemREN=1, imemaddr=0x00000004, iwait=0 on the first FETCH cycle, iload=0x8C220000.
  - Required: cycle 0 ihit=0, iREN=0; cycle 1 iREN=1, iaddr=0x00000004; cycle 2 ihit=1, imemload=0x8C220000, iREN=0.
- Hit after fill: repeat imemaddr=0x00000004 for 3 cycles after the fill.
  - Required: ihit=1 every cycle, iREN stays 0, memory unused.
- Conflict eviction (SETS=16):
  - Fill 0x00000000 (iload=0x11111111), then request 0x00000040: miss, iaddr=0x00000040, fill with 0x22222222.
  - Re-request 0x00000000: miss again, with a new fetch to iaddr=0x00000000.
- Long memory latency: miss on 0x00000100 with iwait=1 for 5 cycles, then 0.
  - Required: iREN=1 and iaddr=0x00000100 stable for all 6 FETCH cycles, ihit=0 throughout, ihit=1 on the next cycle.
- Address change mid-fill: miss on 0x00000008; during FETCH switch imemaddr to 0x0000000C.
  - Required: iaddr stays 0x00000008; after completion, a miss and a new fetch for 0x0000000C.
  - Later, 0x00000008 hits.
- Reset mid-fetch: nRST low for one cycle during FETCH with iwait=1.
  - Required: iREN=0 without waiting for a clock edge, state IDLE, and the previously filled 0x00000004 now misses.
  - With ICACHE_STATS_EN defined: both counters read 0.
